// File: rtl/operand_pair_buffer.sv
// Joins two independently handshaked operand streams into aligned pairs for the AND stage.
// Each stream is buffered in its own FIFO; the Nth A beat always pairs with the Nth B beat.
module operand_pair_buffer #(
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic [INPUT_WIDTH-1:0] a_data_in,
  input  logic                   a_valid_in,
  output logic                   a_ready_out,
  input  logic [INPUT_WIDTH-1:0] b_data_in,
  input  logic                   b_valid_in,
  output logic                   b_ready_out,
  output logic [INPUT_WIDTH-1:0] a_out,
  output logic [INPUT_WIDTH-1:0] b_out,
  output logic                   pair_valid_out,
  input  logic                   pair_ready_in,
  output logic [COUNT_WIDTH-1:0] pair_count_out
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [INPUT_WIDTH-1:0] r_a_mem [FIFO_DEPTH];
  logic [INPUT_WIDTH-1:0] r_b_mem [FIFO_DEPTH];
  logic [PtrW-1:0]        r_a_wptr, r_a_rptr, r_b_wptr, r_b_rptr;
  logic [CntW-1:0]        r_a_cnt, r_b_cnt;
  logic [CntW-1:0]        w_a_cnt_d, w_b_cnt_d;
  logic [INPUT_WIDTH-1:0] r_a_out, r_b_out;
  logic                   r_pair_valid;
  logic [COUNT_WIDTH-1:0] r_count;

  logic w_a_full, w_b_full;
  logic w_a_nonempty, w_b_nonempty;
  logic w_a_push, w_b_push;
  logic w_out_free, w_pop;

  assign w_a_full     = (r_a_cnt == CntW'(FIFO_DEPTH));
  assign w_b_full     = (r_b_cnt == CntW'(FIFO_DEPTH));
  assign w_a_nonempty = (r_a_cnt != '0);
  assign w_b_nonempty = (r_b_cnt != '0);

  // A full FIFO refuses pushes even when it pops on the same edge.
  assign w_a_push = a_valid_in & ~w_a_full;
  assign w_b_push = b_valid_in & ~w_b_full;

  assign w_out_free = ~r_pair_valid | pair_ready_in;
  assign w_pop      = w_a_nonempty & w_b_nonempty & w_out_free;

  always_ff @(posedge clock_in) begin
    if (w_a_push) r_a_mem[r_a_wptr] <= a_data_in;
    if (w_b_push) r_b_mem[r_b_wptr] <= b_data_in;
  end

  always_comb begin
    w_a_cnt_d = r_a_cnt;
    case ({w_a_push, w_pop})
      2'b10:   w_a_cnt_d = r_a_cnt + CntW'(1);
      2'b01:   w_a_cnt_d = r_a_cnt - CntW'(1);
      default: w_a_cnt_d = r_a_cnt;
    endcase
  end

  always_comb begin
    w_b_cnt_d = r_b_cnt;
    case ({w_b_push, w_pop})
      2'b10:   w_b_cnt_d = r_b_cnt + CntW'(1);
      2'b01:   w_b_cnt_d = r_b_cnt - CntW'(1);
      default: w_b_cnt_d = r_b_cnt;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_a_wptr <= '0;
      r_a_rptr <= '0;
      r_a_cnt  <= '0;
      r_b_wptr <= '0;
      r_b_rptr <= '0;
      r_b_cnt  <= '0;
    end else begin
      if (w_a_push) r_a_wptr <= r_a_wptr + PtrW'(1);
      if (w_b_push) r_b_wptr <= r_b_wptr + PtrW'(1);
      if (w_pop) begin
        r_a_rptr <= r_a_rptr + PtrW'(1);
        r_b_rptr <= r_b_rptr + PtrW'(1);
      end
      r_a_cnt <= w_a_cnt_d;
      r_b_cnt <= w_b_cnt_d;
    end
  end

  // Output holds while presented and not consumed; clears on a consume with nothing to reload.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_a_out      <= '0;
      r_b_out      <= '0;
      r_pair_valid <= 1'b0;
    end else if (w_pop) begin
      r_a_out      <= r_a_mem[r_a_rptr];
      r_b_out      <= r_b_mem[r_b_rptr];
      r_pair_valid <= 1'b1;
    end else if (pair_ready_in) begin
      r_pair_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_count <= '0;
    end else if (r_pair_valid & pair_ready_in) begin
      r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  assign a_ready_out    = ~w_a_full;
  assign b_ready_out    = ~w_b_full;
  assign a_out          = r_a_out;
  assign b_out          = r_b_out;
  assign pair_valid_out = r_pair_valid;
  assign pair_count_out = r_count;

endmodule

// File: tb/tb_operand_pair_buffer.sv
// Scoreboard bench for operand_pair_buffer: accepted beats are queued per stream and
// compared against each consumed pair; directed checks cover latency, backpressure and reset.
module tb_operand_pair_buffer;

  logic        clock_in;
  logic        reset_in;
  logic [7:0]  a_data_in, b_data_in;
  logic        a_valid_in, b_valid_in;
  logic        a_ready_out, b_ready_out;
  logic [7:0]  a_out, b_out;
  logic        pair_valid_out;
  logic        pair_ready_in;
  logic [15:0] pair_count_out;

  operand_pair_buffer #(
    .INPUT_WIDTH(8),
    .FIFO_DEPTH (4),
    .COUNT_WIDTH(16)
  ) u_dut (
    .clock_in      (clock_in),
    .reset_in      (reset_in),
    .a_data_in     (a_data_in),
    .a_valid_in    (a_valid_in),
    .a_ready_out   (a_ready_out),
    .b_data_in     (b_data_in),
    .b_valid_in    (b_valid_in),
    .b_ready_out   (b_ready_out),
    .a_out         (a_out),
    .b_out         (b_out),
    .pair_valid_out(pair_valid_out),
    .pair_ready_in (pair_ready_in),
    .pair_count_out(pair_count_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [15:0] exp_count = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((qa.size() != 0 || qb.size() != 0 || pair_valid_out) && g < 50) begin
      tick();
      g++;
    end
    check("drain_left", qa.size() + qb.size() + int'(pair_valid_out), 0);
  endtask

  // Inputs change at posedge+1, so values seen at negedge are what the next edge samples.
  always @(negedge clock_in) begin
    if (reset_in) begin
      qa.delete();
      qb.delete();
      exp_count = '0;
    end else begin
      if (a_valid_in && a_ready_out) qa.push_back(a_data_in);
      if (b_valid_in && b_ready_out) qb.push_back(b_data_in);
      if (pair_valid_out && pair_ready_in) begin
        if (qa.size() == 0 || qb.size() == 0) begin
          check("sb_underflow", 32'(pair_valid_out), 0);
        end else begin
          check("pair_a", a_out, qa.pop_front());
          check("pair_b", b_out, qb.pop_front());
        end
        exp_count = exp_count + 16'd1;
      end
    end
  end

  initial begin
    int na;
    int nb;
    logic acc_a;
    logic acc_b;

    reset_in      = 1'b1;
    a_data_in     = '0;
    b_data_in     = '0;
    a_valid_in    = 1'b0;
    b_valid_in    = 1'b0;
    pair_ready_in = 1'b1;
    tick();
    tick();
    check("rst_a_ready", a_ready_out, 1);
    check("rst_b_ready", b_ready_out, 1);
    check("rst_valid", pair_valid_out, 0);
    check("rst_a_out", a_out, 0);
    check("rst_count", pair_count_out, 0);
    reset_in = 1'b0;
    tick();

    // 1: single pair latency
    a_data_in = 8'hF0; a_valid_in = 1'b1;
    b_data_in = 8'h3C; b_valid_in = 1'b1;
    tick();
    a_valid_in = 1'b0; b_valid_in = 1'b0;
    check("t1_valid_k", pair_valid_out, 0);
    tick();
    check("t1_valid_k1", pair_valid_out, 1);
    check("t1_a_out", a_out, 8'hF0);
    check("t1_b_out", b_out, 8'h3C);
    tick();
    check("t1_valid_k2", pair_valid_out, 0);
    check("t1_count", pair_count_out, 1);

    // 2: A first, then B; ordered join
    for (int i = 1; i <= 3; i++) begin
      a_data_in = 8'(i); a_valid_in = 1'b1;
      tick();
    end
    a_valid_in = 1'b0;
    tick();
    check("t2_no_pair", pair_valid_out, 0);
    for (int i = 1; i <= 3; i++) begin
      b_data_in = 8'(i * 16); b_valid_in = 1'b1;
      tick();
    end
    b_valid_in = 1'b0;
    wait_idle();
    check("t2_count", pair_count_out, exp_count);

    // 3: A FIFO full
    for (int i = 1; i <= 4; i++) begin
      a_data_in = 8'(i); a_valid_in = 1'b1;
      tick();
    end
    check("t3_full", a_ready_out, 0);
    a_data_in = 8'h05;
    tick();
    tick();
    check("t3_still_full", a_ready_out, 0);
    check("t3_no_pair", pair_valid_out, 0);
    a_valid_in = 1'b0;
    b_data_in  = 8'h40; b_valid_in = 1'b1;
    tick();
    b_valid_in = 1'b0;
    check("t3_ready_k", a_ready_out, 0);
    tick();
    check("t3_ready_k1", a_ready_out, 1);
    check("t3_pair_out", pair_valid_out, 1);
    for (int i = 1; i <= 3; i++) begin
      b_data_in = 8'(8'h40 + i); b_valid_in = 1'b1;
      tick();
    end
    b_valid_in = 1'b0;
    wait_idle();

    // 4: backpressure fill, then drain at full rate
    pair_ready_in = 1'b0;
    a_data_in = 8'h80; a_valid_in = 1'b1;
    b_data_in = 8'h90; b_valid_in = 1'b1;
    na = 0; nb = 0;
    for (int i = 0; i < 10; i++) begin
      acc_a = a_ready_out;
      acc_b = b_ready_out;
      tick();
      if (acc_a) begin na++; a_data_in = a_data_in + 8'd1; end
      if (acc_b) begin nb++; b_data_in = b_data_in + 8'd1; end
    end
    a_valid_in = 1'b0; b_valid_in = 1'b0;
    check("t4_na", na, 5);
    check("t4_nb", nb, 5);
    check("t4_a_ready", a_ready_out, 0);
    check("t4_b_ready", b_ready_out, 0);
    check("t4_valid", pair_valid_out, 1);
    check("t4_hold_a", a_out, 8'h80);
    check("t4_hold_b", b_out, 8'h90);
    tick();
    check("t4_hold_a2", a_out, 8'h80);
    pair_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_stream", pair_valid_out, 1);
      tick();
    end
    check("t4_done", pair_valid_out, 0);
    wait_idle();

    // 5: async reset with data buffered
    pair_ready_in = 1'b0;
    a_valid_in = 1'b1; b_valid_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_data_in = 8'(8'hA0 + i);
      b_data_in = 8'(8'hB0 + i);
      tick();
    end
    a_valid_in = 1'b0; b_valid_in = 1'b0;
    check("t5_valid_pre", pair_valid_out, 1);
    #2;
    reset_in = 1'b1;
    #1;
    check("t5_rst_valid", pair_valid_out, 0);
    check("t5_rst_a_out", a_out, 0);
    check("t5_rst_b_out", b_out, 0);
    check("t5_rst_count", pair_count_out, 0);
    tick();
    reset_in = 1'b0;
    pair_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_stale", pair_valid_out, 0);
    end
    check("t5_count", pair_count_out, 0);
    check("t5_a_ready", a_ready_out, 1);

    // 6: counter wrap via 65535 streamed pairs plus one
    na = 0; nb = 0;
    for (int g = 0; g < 70000; g++) begin
      a_valid_in = (na < 65535);
      b_valid_in = (nb < 65535);
      if (!a_valid_in && !b_valid_in) break;
      acc_a = a_valid_in & a_ready_out;
      acc_b = b_valid_in & b_ready_out;
      tick();
      if (acc_a) begin na++; a_data_in = 8'(na); end
      if (acc_b) begin nb++; b_data_in = ~8'(nb); end
    end
    a_valid_in = 1'b0; b_valid_in = 1'b0;
    wait_idle();
    check("t6_count_max", pair_count_out, 16'hFFFF);
    check("t6_model_max", pair_count_out, exp_count);
    a_data_in = 8'h5A; a_valid_in = 1'b1;
    b_data_in = 8'hA5; b_valid_in = 1'b1;
    tick();
    a_valid_in = 1'b0; b_valid_in = 1'b0;
    wait_idle();
    check("t6_count_wrap", pair_count_out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
